// File: rtl/intr_ctrl.sv
// Interrupt controller: synchronizes external lines, latches rising edges as
// pending, and presents one request at a time through the
// request / take / mret handshake with the control unit (no nesting).
module intr_ctrl #(
  parameter  int N_SRC       = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int ID_W        = $clog2(N_SRC)
) (
  input  logic              clk,
  input  logic              RST_N,
  input  logic [N_SRC-1:0]  irq_in,
  input  logic              mie,
  input  logic [N_SRC-1:0]  src_en,
  input  logic              int_taken,
  input  logic              mret_exec,
  output logic              intr,
  output logic [ID_W-1:0]   int_id,
  output logic [N_SRC-1:0]  pending,
  output logic              in_service
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q;
  logic [N_SRC-1:0]                  hist_q;
  logic [N_SRC-1:0]                  edge_det;
  logic [N_SRC-1:0]                  eligible;
  logic [N_SRC-1:0]                  clr_mask;
  logic [N_SRC-1:0]                  pending_q, pending_d;
  logic [ID_W-1:0]                   win_id;
  logic [ID_W-1:0]                   int_id_q, int_id_d;
  state_t                            state_q, state_d;
  logic                              intr_q, intr_d;
  logic                              in_service_q, in_service_d;

  // Input synchronizer chain plus one history stage for edge detection.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign eligible = mie ? (pending_q & src_en) : '0;

  // Lowest eligible index wins; scan downward so the last hit is the lowest.
  always_comb begin
    win_id = '0;
    for (int unsigned i = N_SRC; i > 0; i--) begin
      if (eligible[i-1]) win_id = ID_W'(i - 1);
    end
  end

  // Pending bits: a new edge overrides a same-cycle clear on the taken source.
  always_comb begin
    clr_mask = '0;
    if (state_q == REQ && int_taken) clr_mask[int_id_q] = 1'b1;
    pending_d = (pending_q & ~clr_mask) | edge_det;
  end

  // State, id and pending registers.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      int_id_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      int_id_q  <= int_id_d;
      pending_q <= pending_d;
    end
  end

  // Next-state logic; int_id only loads when leaving IDLE.
  always_comb begin
    state_d  = state_q;
    int_id_d = int_id_q;
    case (state_q)
      IDLE: begin
        if (eligible != '0) begin
          state_d  = REQ;
          int_id_d = win_id;
        end
      end
      REQ: begin
        if (int_taken)                state_d = SERVICE;
        else if (!eligible[int_id_q]) state_d = IDLE;
      end
      SERVICE: begin
        if (mret_exec) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state, so intr/in_service come straight from flops.
  always_comb begin
    intr_d       = (state_d == REQ);
    in_service_d = (state_d == SERVICE);
  end

  // Registered request / in-service outputs.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      intr_q       <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      intr_q       <= intr_d;
      in_service_q <= in_service_d;
    end
  end

  assign intr       = intr_q;
  assign in_service = in_service_q;
  assign int_id     = int_id_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: a behavioural model predicts the outputs
// after each clock edge (and after an asynchronous reset); a monitor compares.
module tb_intr_ctrl;
  localparam int N  = 4;
  localparam int S  = 2;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  irq_in;
  logic          mie;
  logic [N-1:0]  src_en;
  logic          int_taken;
  logic          mret_exec;
  logic          intr;
  logic [IW-1:0] int_id;
  logic [N-1:0]  pending;
  logic          in_service;

  intr_ctrl #(.N_SRC(N), .SYNC_STAGES(S)) dut (
    .clk        (clk),
    .RST_N      (rst_n),
    .irq_in     (irq_in),
    .mie        (mie),
    .src_en     (src_en),
    .int_taken  (int_taken),
    .mret_exec  (mret_exec),
    .intr       (intr),
    .int_id     (int_id),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          intr;
    logic [IW-1:0] id;
    logic [N-1:0]  pend;
    logic          insvc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  // Stimulus-side settings applied at each falling edge.
  logic         rst_v;
  logic         mie_v;
  logic [N-1:0] en_v;

  // Reference model: mode of the handshake, chosen source, pending set,
  // and the history of irq values sampled at past rising edges.
  typedef enum {M_IDLE, M_REQ, M_SVC} mmode_t;
  mmode_t       m_mode;
  int           m_id;
  logic [N-1:0] m_pend;
  logic [N-1:0] past [0:S];

  function automatic int lowest(input logic [N-1:0] v);
    int r = 0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE;
    m_id   = 0;
    m_pend = '0;
    for (int j = 0; j <= S; j++) past[j] = '0;
  endfunction

  // Predict the outputs after the coming rising edge.
  function automatic void model_step(input logic [N-1:0] irq, input logic tk, input logic mr);
    logic [N-1:0] ev, elig, clr;
    exp_t e;
    if (!rst_v) begin
      model_reset();
      sb.push_back('0);
      return;
    end
    // An event reaches pending S edges after it is first sampled.
    ev   = past[S-1] & ~past[S];
    elig = mie_v ? (m_pend & en_v) : '0;
    clr  = '0;
    case (m_mode)
      M_IDLE: if (elig != '0) begin m_id = lowest(elig); m_mode = M_REQ; end
      M_REQ: begin
        if (tk) begin clr[m_id] = 1'b1; m_mode = M_SVC; end
        else if (!(mie_v && en_v[m_id])) m_mode = M_IDLE;
      end
      M_SVC: if (mr) m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
    m_pend = (m_pend & ~clr) | ev;
    for (int j = S; j > 0; j--) past[j] = past[j-1];
    past[0] = irq;
    e.intr  = (m_mode == M_REQ);
    e.id    = IW'(m_id);
    e.pend  = m_pend;
    e.insvc = (m_mode == M_SVC);
    sb.push_back(e);
  endfunction

  task automatic cycle(input logic [N-1:0] irq, input logic tk, input logic mr);
    @(negedge clk);
    irq_in    = irq;
    int_taken = tk;
    mret_exec = mr;
    mie       = mie_v;
    src_en    = en_v;
    rst_n     = rst_v;
    model_step(irq, tk, mr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, 1'b0, 1'b0);
  endtask

  // Outputs must all be zero while reset is asserted.
  task automatic check_reset();
    if ({intr, int_id, pending, in_service} !== '0) begin
      miscompares++;
      $display("FAIL reset state @%0t: intr=%b id=%0d pend=%b insvc=%b",
               $time, intr, int_id, pending, in_service);
    end
  endtask

  // Idle until intr rises; report a failure if the wait expires.
  task automatic wait_intr(input int max_cycles);
    int k = 0;
    while (intr !== 1'b1 && k < max_cycles) begin
      idle(1);
      k++;
    end
    if (intr !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout @%0t: intr not raised within %0d cycles", $time, max_cycles);
    end
  endtask

  // Assert reset between clock edges; outputs must clear without a clock.
  task automatic async_reset();
    @(posedge clk);
    #2;
    rst_v = 1'b0;
    model_reset();
    sb.push_back('0);
    rst_n = 1'b0;
  endtask

  // Monitor: compare after every rising edge and after reset assertion.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        vectors++;
        if ({intr, int_id, pending, in_service} !== mon_e) begin
          miscompares++;
          $display("FAIL outputs @%0t: got intr=%b id=%0d pend=%b insvc=%b, want intr=%b id=%0d pend=%b insvc=%b",
                   $time, intr, int_id, pending, in_service,
                   mon_e.intr, mon_e.id, mon_e.pend, mon_e.insvc);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; irq_in = '0; mie = 1'b0; src_en = '0; int_taken = 1'b0; mret_exec = 1'b0;
    rst_v = 1'b0; mie_v = 1'b1; en_v = 4'hF;
    model_reset();
    idle(3);
    check_reset();
    rst_v = 1'b1;
    idle(2);

    // Single source request, take, return.
    cycle(4'b0100, 1'b0, 1'b0);
    wait_intr(10);
    idle(1);
    cycle('0, 1'b1, 1'b0); idle(2);
    cycle('0, 1'b0, 1'b1); idle(3);

    // Two simultaneous sources: lower index first, then the other.
    cycle(4'b1010, 1'b0, 1'b0); idle(5);
    cycle('0, 1'b1, 1'b0); idle(2);
    cycle('0, 1'b0, 1'b1); idle(3);
    cycle('0, 1'b1, 1'b0); idle(1);
    cycle('0, 1'b0, 1'b1); idle(3);

    // Global and per-source masking.
    mie_v = 1'b0;
    cycle(4'b0001, 1'b0, 1'b0); idle(5);
    mie_v = 1'b1; idle(2);
    en_v = 4'b1110; idle(3);
    en_v = 4'hF; idle(2);
    cycle('0, 1'b1, 1'b0); idle(1);
    cycle('0, 1'b0, 1'b1); idle(3);

    // New edge on the source being taken in the same cycle.
    cycle(4'b0100, 1'b0, 1'b0); idle(5);
    cycle(4'b0100, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0); idle(2);
    cycle('0, 1'b0, 1'b1); idle(3);
    cycle('0, 1'b1, 1'b0); idle(1);
    cycle('0, 1'b0, 1'b1); idle(3);

    // Handshake pulses in the wrong states.
    cycle('0, 1'b1, 1'b0); idle(1);
    cycle(4'b1000, 1'b0, 1'b0); idle(5);
    cycle('0, 1'b0, 1'b1); idle(1);
    cycle('0, 1'b1, 1'b0); idle(1);
    cycle('0, 1'b0, 1'b1); idle(3);

    // Reset in service, released with a source held high.
    cycle(4'b0010, 1'b0, 1'b0); idle(5);
    cycle('0, 1'b1, 1'b0);
    async_reset();
    #1;
    check_reset();
    cycle(4'b0010, 1'b0, 1'b0);
    cycle(4'b0010, 1'b0, 1'b0);
    rst_v = 1'b1;
    for (int i = 0; i < 6; i++) cycle(4'b0010, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0); idle(1);
    cycle('0, 1'b0, 1'b1); idle(3);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r_irq;
      r_irq = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 24) == 0) mie_v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) en_v  = N'($urandom);
      cycle(r_irq, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    end
    idle(2);

    @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
